// File: rtl/alu_resp_framer_if.sv
// alu_resp_framer_if
//   Bundles the result-input handshake, the byte-stream output toward uart_tx
//   and the busy flag of alu_resp_framer.
//   master : the framer side (accepts results, drives the byte stream)
//   slave  : the environment side (offers results, consumes the byte stream)
//
//   res_valid_i / res_ready_o   result handshake
//   res_opcode_i [7:0]          opcode that produced the result
//   res_data_i   [DATA_WIDTH]   ALU result word
//   m_axis_tdata_o [7:0]        byte toward uart_tx
//   m_axis_tvalid_o             byte valid
//   m_axis_tready_i             uart_tx accepts byte
//   busy_o                      packet in flight
interface alu_resp_framer_if #(
  parameter int DATA_BYTES = 4,
  parameter int DATA_WIDTH = 8 * DATA_BYTES
) ();
  logic                  res_valid_i;
  logic                  res_ready_o;
  logic [7:0]            res_opcode_i;
  logic [DATA_WIDTH-1:0] res_data_i;
  logic [7:0]            m_axis_tdata_o;
  logic                  m_axis_tvalid_o;
  logic                  m_axis_tready_i;
  logic                  busy_o;

  modport master (
    input  res_valid_i, res_opcode_i, res_data_i, m_axis_tready_i,
    output res_ready_o, m_axis_tdata_o, m_axis_tvalid_o, busy_o
  );

  modport slave (
    output res_valid_i, res_opcode_i, res_data_i, m_axis_tready_i,
    input  res_ready_o, m_axis_tdata_o, m_axis_tvalid_o, busy_o
  );
endinterface

// File: rtl/alu_resp_framer.sv
// alu_resp_framer
//   Transmit-side packet framer for the UART ALU path. Latches one result word
//   and its opcode, then emits a response packet one byte per stream beat:
//     opcode, 8'h00, N[7:0], N[15:8], data bytes LSB first  (N = 4 + DATA_BYTES)
//   Ports:
//     clk_i  system clock
//     rst_i  synchronous active-high reset
//     bus    alu_resp_framer_if.master (result handshake, byte stream, busy)
//
//   state | meaning
//   IDLE  | ready for a result, no stream activity
//   SEND  | packet in flight, bytes presented from the latched copy
module alu_resp_framer #(
  parameter int DATA_BYTES = 4,
  parameter int DATA_WIDTH = 8 * DATA_BYTES
) (
  input logic               clk_i,
  input logic               rst_i,
  alu_resp_framer_if.master bus
);

  localparam int          N     = 4 + DATA_BYTES;
  localparam int          IDX_W = $clog2(N);
  localparam logic [15:0] LEN   = 16'(N);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                state_q;
  logic [IDX_W-1:0]      idx_q;
  logic [7:0]            opcode_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [7:0]            tdata_q;
  logic                  tvalid_q;
  logic                  ready_q;
  logic                  busy_q;

  // Byte k of the packet built from the latched copy.
  function automatic logic [7:0] byte_at(input logic [IDX_W-1:0] k);
    logic [7:0] r;
    r = 8'h00;
    if (k == IDX_W'(0))      r = opcode_q;
    else if (k == IDX_W'(2)) r = LEN[7:0];
    else if (k == IDX_W'(3)) r = LEN[15:8];
    for (int b = 0; b < DATA_BYTES; b++) begin
      if (k == IDX_W'(b + 4)) r = data_q[b*8 +: 8];
    end
    return r;
  endfunction

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      opcode_q <= '0;
      data_q   <= '0;
      tdata_q  <= 8'h00;
      tvalid_q <= 1'b0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.res_valid_i && ready_q) begin
            opcode_q <= bus.res_opcode_i;
            data_q   <= bus.res_data_i;
            idx_q    <= '0;
            // byte0 is the opcode, so it can be loaded straight from the input
            tdata_q  <= bus.res_opcode_i;
            tvalid_q <= 1'b1;
            ready_q  <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= SEND;
          end
        end
        SEND: begin
          if (tvalid_q && bus.m_axis_tready_i) begin
            if (idx_q == LAST) begin
              tvalid_q <= 1'b0;
              ready_q  <= 1'b1;
              busy_q   <= 1'b0;
              state_q  <= IDLE;
            end else begin
              idx_q   <= idx_q + 1'b1;
              tdata_q <= byte_at(idx_q + 1'b1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.res_ready_o     = ready_q;
  assign bus.m_axis_tdata_o  = tdata_q;
  assign bus.m_axis_tvalid_o = tvalid_q;
  assign bus.busy_o          = busy_q;

endmodule

// File: doc/alu_resp_framer.md
Name: alu_resp_framer

Overview:
- Transmit-side packet framer for the UART ALU path.
- Accepts one ALU result word plus its opcode and serializes it as a fixed-format response packet, one byte per AXI-stream beat.
- Output drives the s_axis_* input of the uart_tx instance, which runs at prescale 54.
- It is the transmitting counterpart of the receive-side command parser; its output replaces the direct rx-to-tx echo loop.

Parameters:
- DATA_BYTES, 4, number of result payload bytes per packet (1..8).
- DATA_WIDTH, 8*DATA_BYTES, result word width in bits; derived, do not override independently.

Ports:
- clk_i  input  1  system clock
- rst_i  input  1  synchronous, active-high reset
- res_valid_i  input  1  result word and opcode are valid
- res_ready_o  output  1  framer can accept a result this cycle
- res_opcode_i  input  8  opcode of the command that produced the result
- res_data_i  input  DATA_WIDTH  ALU result word
- m_axis_tdata_o  output  8  byte to uart_tx
- m_axis_tvalid_o  output  1  byte valid
- m_axis_tready_i  input  1  uart_tx accepts byte
- busy_o  output  1  packet in flight

Behaviour:
- Clocking and reset: single clock domain; reset is synchronous and active-high.
- Reset values: state=IDLE, res_ready_o=1, m_axis_tvalid_o=0, m_axis_tdata_o=8'h00, busy_o=0, byte index=0, latched opcode and data=0.
- Packet format, N = 4 + DATA_BYTES bytes, in order:
  - byte0 = opcode;
  - byte1 = 8'h00 (reserved);
  - byte2 = N[7:0];
  - byte3 = N[15:8];
  - bytes 4..N-1 = result data, least significant byte first.
  - With default DATA_BYTES=4, N=8 and the length field is 0x0008.
- IDLE state:
  - res_ready_o=1, busy_o=0, m_axis_tvalid_o=0.
  - On res_valid_i && res_ready_o: latch res_opcode_i and res_data_i, set index=0, go to SEND.
- SEND state:
  - res_ready_o=0, busy_o=1.
  - m_axis_tvalid_o rises on the cycle after acceptance, carrying byte0. This is a 1-cycle input-to-first-byte latency.
- Outputs are registered:
  - m_axis_tdata_o and m_axis_tvalid_o hold stable until m_axis_tready_i is sampled high.
  - tvalid never drops without a handshake.
- On each handshake (tvalid && tready) with index < N-1: index increments and the next byte is presented on the following cycle. Back-to-back beats are allowed when tready stays high.
- On the handshake with index == N-1: tvalid=0 next cycle, state returns to IDLE, and res_ready_o=1 on that same next cycle.
  - This gives exactly one cycle with no tvalid between packets.
- Input changes during SEND (res_data_i, res_opcode_i, res_valid_i) are ignored; the latched copy is transmitted.
- A res_valid_i held high across packets is accepted on the first IDLE cycle.
- Byte index is a counter sized clog2(N). It never wraps inside a packet and resets to 0 on every acceptance.
- m_axis_tready_i high while tvalid=0 has no effect.
- Reset asserted mid-packet:
  - abort immediately and return to reset values on the next edge;
  - the partial packet is not resumed; the downstream receiver resynchronizes via the length field.
- Throughput: with tready held high, one packet per N+1 cycles.

Test Plan:
1. Reset, then one result with opcode=8'h03, data=32'hDEADBEEF and tready tied high -> bytes 03,00,08,00,EF,BE,AD,DE on consecutive cycles; first tvalid 1 cycle after acceptance; res_ready_o high again the cycle after byte DE.
2. Same packet with tready toggling 1,0,0,1,0 repeatedly -> every byte held stable through stalls; no byte dropped or duplicated; byte order unchanged.
3. res_valid_i held high with data changing every cycle (values 1,2,3,...) -> only the value present at each IDLE acceptance is sent; res_ready_o=0 throughout SEND; one gap cycle between packets.
4. rst_i pulsed for one cycle after the third byte handshake -> next cycle tvalid=0, res_ready_o=1, busy_o=0; a new result (opcode=8'h01, data=32'h00000001) then sends a complete 8-byte packet starting at byte0.
5. DATA_BYTES=2 build, opcode=8'h7F, data=16'hA55A -> bytes 7F,00,06,00,5A,A5.
6. Random results and random tready over 1000 packets, checked by a scoreboard against uart_tx output via the uart_rx loopback -> all packets match the format; no protocol violations (tvalid held until handshake, tdata stable while stalled).
